// File: rtl/esi_mmio_pkg.sv
// Shared types, error codes and address-check helper for the MMIO register-file responder.
package esi_mmio_pkg;

    typedef logic [31:0] mmio_addr_t;
    typedef logic [31:0] mmio_data_t;
    typedef logic [7:0]  mmio_err_t;

    localparam mmio_err_t MMIO_OK        = 8'd0;
    localparam mmio_err_t MMIO_ERR_RANGE = 8'd1;
    localparam mmio_err_t MMIO_ERR_ALIGN = 8'd2;
    localparam mmio_err_t MMIO_ERR_RO    = 8'd3;

    typedef struct packed {
        mmio_data_t data;
        mmio_err_t  err;
    } mmio_rd_rsp_t;

    typedef enum logic [1:0] {
        RSP_EMPTY = 2'd0,
        RSP_HOLD  = 2'd1,
        RSP_FULL  = 2'd2
    } rsp_state_e;

    // Misalignment wins over out-of-range when both apply.
    function automatic mmio_err_t mmio_addr_check(input mmio_addr_t addr, input int unsigned num_regs);
        if (addr[1:0] != 2'b00) begin
            return MMIO_ERR_ALIGN;
        end
        if (addr >= mmio_addr_t'(num_regs << 2)) begin
            return MMIO_ERR_RANGE;
        end
        return MMIO_OK;
    endfunction

endpackage

// File: rtl/esi_mmio_resp_fifo.sv
// In-order response FIFO with EMPTY/HOLD/FULL state machine; pointers carry one extra
// bit so full and empty are distinguishable.
module esi_mmio_resp_fifo
    import esi_mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             pop_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_d;
    logic             do_push, do_pop;
    rsp_state_e       state_q, state_d;

    assign do_push  = push_i && push_ready_o;
    assign do_pop   = valid_o && pop_ready_i;
    assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
    assign count_d  = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RSP_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (do_push) state_d = RSP_HOLD;
            RSP_HOLD: begin
                if (count_d == FULL_COUNT)  state_d = RSP_FULL;
                else if (count_d == '0)     state_d = RSP_EMPTY;
            end
            RSP_FULL: begin
                if (count_d == '0)              state_d = RSP_EMPTY;
                else if (count_d != FULL_COUNT) state_d = RSP_HOLD;
            end
            default: state_d = RSP_EMPTY;
        endcase
    end

    // Ready looks only at registered state, so a pop cannot free a slot in the same cycle.
    always_comb begin
        valid_o      = (state_q != RSP_EMPTY);
        push_ready_o = (state_q != RSP_FULL);
        data_o       = valid_o ? mem_q[rd_ptr_q[PW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/esi_mmio_regfile_responder.sv
// MMIO target answering read/write command streams from a local 32-bit register file.
// Define ESI_MMIO_RO_ID_EN to make register 0 a read-only ID register.
module esi_mmio_regfile_responder
    import esi_mmio_pkg::*;
#(
    parameter int         NUM_REGS   = 16,
    parameter int         RESP_DEPTH = 4,
    parameter mmio_data_t ID_VALUE   = 32'hE51_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [31:0] rd_req_addr,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [31:0] rd_rsp_data,
    output logic [7:0]  rd_rsp_error,
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    input  logic [31:0] wr_req_addr,
    input  logic [31:0] wr_req_data,
    output logic        wr_rsp_valid,
    input  logic        wr_rsp_ready,
    output logic [7:0]  wr_rsp_error
);

    localparam int IDX_W = $clog2(NUM_REGS);
`ifdef ESI_MMIO_RO_ID_EN
    localparam bit RO_ID_EN = 1'b1;
`else
    localparam bit RO_ID_EN = 1'b0;
`endif

    mmio_data_t       regs_q [NUM_REGS];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    mmio_err_t        rd_err, wr_err;
    mmio_rd_rsp_t     rd_rsp_in, rd_rsp_out;
    logic             wr_commit;

    assign rd_idx = rd_req_addr[2 +: IDX_W];
    assign wr_idx = wr_req_addr[2 +: IDX_W];
    assign rd_err = mmio_addr_check(rd_req_addr, NUM_REGS);

    // Read data is sampled from the pre-edge register state: read-before-write.
    always_comb begin
        rd_rsp_in.err  = rd_err;
        rd_rsp_in.data = '0;
        if (rd_err == MMIO_OK) begin
            rd_rsp_in.data = (RO_ID_EN && rd_idx == '0) ? ID_VALUE : regs_q[rd_idx];
        end
    end

    always_comb begin
        wr_err = mmio_addr_check(wr_req_addr, NUM_REGS);
        if (RO_ID_EN && wr_err == MMIO_OK && wr_idx == '0) begin
            wr_err = MMIO_ERR_RO;
        end
    end

    assign wr_commit = wr_req_valid && wr_req_ready && (wr_err == MMIO_OK);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (wr_commit && wr_idx == IDX) begin
                    regs_q[gi] <= wr_req_data;
                end
            end
        end
    endgenerate

    esi_mmio_resp_fifo #(
        .WIDTH ($bits(mmio_rd_rsp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_rd_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rd_req_valid),
        .push_data_i  (rd_rsp_in),
        .push_ready_o (rd_req_ready),
        .valid_o      (rd_rsp_valid),
        .data_o       (rd_rsp_out),
        .pop_ready_i  (rd_rsp_ready)
    );

    assign rd_rsp_data  = rd_rsp_out.data;
    assign rd_rsp_error = rd_rsp_out.err;

    esi_mmio_resp_fifo #(
        .WIDTH ($bits(mmio_err_t)),
        .DEPTH (RESP_DEPTH)
    ) u_wr_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (wr_req_valid),
        .push_data_i  (wr_err),
        .push_ready_o (wr_req_ready),
        .valid_o      (wr_rsp_valid),
        .data_o       (wr_rsp_error),
        .pop_ready_i  (wr_rsp_ready)
    );

endmodule

// File: tb/tb_esi_mmio_regfile_responder.sv
// Scoreboard bench for esi_mmio_regfile_responder (honours ESI_MMIO_RO_ID_EN if defined).
module tb_esi_mmio_regfile_responder;

    localparam int          NUM_REGS   = 16;
    localparam int          RESP_DEPTH = 4;
    localparam logic [31:0] ID_VALUE   = 32'hE51_0001;
`ifdef ESI_MMIO_RO_ID_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_valid, rd_req_ready;
    logic [31:0] rd_req_addr;
    logic        rd_rsp_valid, rd_rsp_ready;
    logic [31:0] rd_rsp_data;
    logic [7:0]  rd_rsp_error;
    logic        wr_req_valid, wr_req_ready;
    logic [31:0] wr_req_addr, wr_req_data;
    logic        wr_rsp_valid, wr_rsp_ready;
    logic [7:0]  wr_rsp_error;

    int checks   = 0;
    int failures = 0;

    logic [39:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [31:0] model[NUM_REGS];

    always #5 clk = ~clk;

    esi_mmio_regfile_responder #(
        .NUM_REGS   (NUM_REGS),
        .RESP_DEPTH (RESP_DEPTH),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_error (rd_rsp_error),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_rsp_valid (wr_rsp_valid),
        .wr_rsp_ready (wr_rsp_ready),
        .wr_rsp_error (wr_rsp_error)
    );

    function automatic logic [7:0] exp_err(input logic [31:0] a, input bit is_wr);
        if (a[1:0] != 2'b00) return 8'd2;
        if (a >= 32'(4 * NUM_REGS)) return 8'd1;
        if (is_wr && RO && a[5:2] == 4'd0) return 8'd3;
        return 8'd0;
    endfunction

    function automatic logic [31:0] exp_rd_data(input logic [31:0] a);
        if (exp_err(a, 1'b0) != 8'd0) return 32'd0;
        if (RO && a[5:2] == 4'd0) return ID_VALUE;
        return model[a[5:2]];
    endfunction

    // Response scoreboard: compare every handshaken response against the queue head.
    always @(negedge clk) begin
        if (!rst && rd_rsp_valid && rd_rsp_ready) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got data=%h err=%0d required none", rd_rsp_data, rd_rsp_error);
            end else begin
                logic [39:0] e;
                e = rd_q.pop_front();
                if ({rd_rsp_data, rd_rsp_error} !== e) begin
                    failures++;
                    $display("FAIL rd_rsp got data=%h err=%0d required data=%h err=%0d", rd_rsp_data, rd_rsp_error, e[39:8], e[7:0]);
                end else begin
                    $display("rd rsp data=%h err=%0d ok", rd_rsp_data, rd_rsp_error);
                end
            end
        end
        if (!rst && wr_rsp_valid && wr_rsp_ready) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected got err=%0d required none", wr_rsp_error);
            end else begin
                logic [7:0] e;
                e = wr_q.pop_front();
                if (wr_rsp_error !== e) begin
                    failures++;
                    $display("FAIL wr_rsp got err=%0d required err=%0d", wr_rsp_error, e);
                end else begin
                    $display("wr rsp err=%0d ok", wr_rsp_error);
                end
            end
        end
    end

    // Drive a read and/or write starting now (posedge+1); returns at posedge+1 after acceptance.
    task automatic issue(input bit do_rd, input logic [31:0] ra, input bit do_wr, input logic [31:0] wa, input logic [31:0] wd);
        bit rd_pend, wr_pend, rd_acc, wr_acc;
        logic [7:0] e;
        int n;
        rd_pend = do_rd;
        wr_pend = do_wr;
        n = 0;
        rd_req_valid = do_rd;
        rd_req_addr  = ra;
        wr_req_valid = do_wr;
        wr_req_addr  = wa;
        wr_req_data  = wd;
        while ((rd_pend || wr_pend) && n < 50) begin
            @(negedge clk);
            rd_acc = rd_pend && rd_req_ready;
            wr_acc = wr_pend && wr_req_ready;
            if (rd_acc) rd_q.push_back({exp_rd_data(ra), exp_err(ra, 1'b0)});
            if (wr_acc) begin
                e = exp_err(wa, 1'b1);
                wr_q.push_back(e);
                if (e == 8'd0) model[wa[5:2]] = wd;
            end
            @(posedge clk);
            #1;
            if (rd_acc) begin rd_pend = 1'b0; rd_req_valid = 1'b0; end
            if (wr_acc) begin wr_pend = 1'b0; wr_req_valid = 1'b0; end
            n++;
        end
        if (rd_pend || wr_pend) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout got pending rd=%0b wr=%0b required accepted", rd_pend, wr_pend);
            rd_req_valid = 1'b0;
            wr_req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got rd_left=%0d wr_left=%0d required 0", rd_q.size(), wr_q.size());
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < NUM_REGS; i++) issue(1'b1, 32'(4 * i), 1'b0, 32'd0, 32'd0);
        wait_drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b1;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_rsp_valid, wr_rsp_valid, rd_req_ready, wr_req_ready} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_handshake got %b required 0011", {rd_rsp_valid, wr_rsp_valid, rd_req_ready, wr_req_ready});
        end
        checks++;
        if (rd_rsp_data !== 32'd0 || rd_rsp_error !== 8'd0 || wr_rsp_error !== 8'd0) begin
            failures++;
            $display("FAIL reset_data got data=%h rerr=%0d werr=%0d required 0", rd_rsp_data, rd_rsp_error, wr_rsp_error);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_rsp_valid, wr_rsp_valid, rd_req_ready, wr_req_ready} !== 4'b0011) begin
            failures++;
            $display("FAIL post_reset_handshake got %b required 0011", {rd_rsp_valid, wr_rsp_valid, rd_req_ready, wr_req_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_post_reset_read();
        issue(1'b1, 32'h8, 1'b0, 32'd0, 32'd0);
        checks++;
        if (rd_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency got valid=%b required 1", rd_rsp_valid);
        end
        issue(1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
        wait_drain();
    endtask

    task automatic test_write_read();
        issue(1'b0, 32'd0, 1'b1, 32'h4, 32'hCAFE_F00D);
        checks++;
        if (wr_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_latency got valid=%b required 1", wr_rsp_valid);
        end
        issue(1'b1, 32'h4, 1'b0, 32'd0, 32'd0);
        wait_drain();
    endtask

    task automatic test_addr_errors();
        issue(1'b1, 32'h6, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'h41, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'h3C, 1'b0, 32'd0, 32'd0);
        issue(1'b0, 32'd0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        issue(1'b0, 32'd0, 1'b1, 32'h42, 32'hDEAD_BEEF);
        issue(1'b0, 32'd0, 1'b1, 32'h9, 32'hDEAD_BEEF);
        issue(1'b0, 32'd0, 1'b1, 32'h0, 32'h0000_0055);
        issue(1'b0, 32'd0, 1'b1, 32'h3C, 32'h1234_5678);
        wait_drain();
        read_all();
    endtask

    task automatic test_back_pressure();
        int accepted;
        logic [31:0] held_data;
        logic [7:0]  held_err;
        accepted = 0;
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 32'(4 * (i + 1));
            @(negedge clk);
            checks++;
            if (rd_req_ready !== (i < RESP_DEPTH)) begin
                failures++;
                $display("FAIL fill_ready[%0d] got %b required %b", i, rd_req_ready, (i < RESP_DEPTH));
            end
            if (rd_req_ready) begin
                rd_q.push_back({exp_rd_data(rd_req_addr), exp_err(rd_req_addr, 1'b0)});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        rd_req_valid = 1'b0;
        checks++;
        if (accepted != RESP_DEPTH) begin
            failures++;
            $display("FAIL fill_count got %0d required %0d", accepted, RESP_DEPTH);
        end
        @(negedge clk);
        held_data = rd_rsp_data;
        held_err  = rd_rsp_error;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== held_data || rd_rsp_error !== held_err) begin
                failures++;
                $display("FAIL stall_stable got v=%b data=%h err=%0d required v=1 data=%h err=%0d", rd_rsp_valid, rd_rsp_data, rd_rsp_error, held_data, held_err);
            end
        end
        // Pop and push attempt in the same cycle while full: ready must stay low until next cycle.
        @(posedge clk);
        #1;
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 32'h18;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_ready got %b required 0", rd_req_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_pop_ready got %b required 1", rd_req_ready);
        end
        if (rd_req_ready) rd_q.push_back({exp_rd_data(rd_req_addr), exp_err(rd_req_addr, 1'b0)});
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_same_cycle();
        issue(1'b1, 32'hC, 1'b1, 32'hC, 32'h11);
        issue(1'b1, 32'hC, 1'b0, 32'd0, 32'd0);
        wait_drain();
    endtask

    task automatic test_mid_reset();
        wr_rsp_ready = 1'b0;
        issue(1'b0, 32'd0, 1'b1, 32'h4, 32'h1);
        issue(1'b0, 32'd0, 1'b1, 32'h8, 32'h2);
        issue(1'b0, 32'd0, 1'b1, 32'h10, 32'h3);
        checks++;
        if (wr_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL queued_valid got %b required 1", wr_rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wr_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_valid got %b required 0", wr_rsp_valid);
        end
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_replay got %b required 0", wr_rsp_valid);
        end
        read_all();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_post_reset_read();
        test_write_read();
        test_addr_errors();
        test_back_pressure();
        test_same_cycle();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esi_mmio_regfile_responder.md
Name: esi_mmio_regfile_responder

Overview:
MMIO target that terminates the cosim MMIO read/write command streams and answers them from a local 32-bit register file. It sits behind the cosim MMIO bridge, which turns host requests into HW valid/ready commands. It accepts those commands and returns in-order read-data/error and write-error responses, which the bridge feeds back to the host. Read and write channels are independent; each channel preserves its own order.

Parameters:
NUM_REGS, 16, number of 32-bit registers; must be ≥2, power of two
RESP_DEPTH, 4, entries in each response FIFO; power of two, ≥2
ID_VALUE, 32'hE51_0001, value of the read-only register 0 when ESI_MMIO_RO_ID_EN is defined

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous assert, active-high
rd_req_valid  in  1  read command valid
rd_req_ready  out  1  read command accepted when valid & ready
rd_req_addr  in  32  byte address of the read
rd_rsp_valid  out  1  read response valid
rd_rsp_ready  in  1  consumer takes the read response
rd_rsp_data  out  32  read data
rd_rsp_error  out  8  read error code
wr_req_valid  in  1  write command valid
wr_req_ready  out  1  write command accepted when valid & ready
wr_req_addr  in  32  byte address of the write
wr_req_data  in  32  write data
wr_rsp_valid  out  1  write response valid
wr_rsp_ready  in  1  consumer takes the write response
wr_rsp_error  out  8  write error code

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high: ports clk and rst.
- During reset and on the first cycle after it: all registers = 0; both FIFOs empty; rd_rsp_valid = wr_rsp_valid = 0; rd_rsp_data = 0; rd_rsp_error = wr_rsp_error = 0; rd_req_ready = wr_req_ready = 1.
- Reset mid-operation drops every queued response and does not replay it.
- Address decode: index = addr[2 +: log2(NUM_REGS)].
  - Error codes: 0 = OK; 1 = out of range (addr ≥ 4*NUM_REGS); 2 = misaligned (addr[1:0] ≠ 0).
  - Priority: misaligned is checked before out of range.
  - On an error, a read returns data 0, and a write leaves every register unchanged.
- Accept rule: req_ready = !fifo_full for that channel, computed combinationally from registered state.
  - req_ready does not depend on rsp_ready in the same cycle, so it has no combinational path from rsp_ready.
- Read latency: a read accepted at cycle N appears on rd_rsp_* no earlier than cycle N+1.
  - With an empty FIFO and rd_rsp_ready = 1, the response is visible at N+1 and consumed at N+1.
- Write effect: a write commits at the edge ending its accept cycle. Its response appears at N+1.
- Same-cycle read and write to the same index: the read returns the old value (read-before-write).
- Simultaneous push and pop on a full FIFO:
  - req_ready stays 0 that cycle, because ready is computed from registered state.
  - Next cycle the FIFO holds RESP_DEPTH-1 entries and ready returns to 1.
- Response stability: while rsp_valid = 1 and rsp_ready = 0, rsp_data and rsp_error hold stable.
- FIFO pointers wrap modulo RESP_DEPTH. Occupancy is tracked with an extra pointer bit to distinguish full from empty.
- Per-channel response FSM:
  - States are EMPTY, HOLD, FULL.
  - EMPTY→HOLD on push.
  - HOLD→FULL when occupancy reaches RESP_DEPTH.
  - Any→EMPTY when the last entry is popped.

Optional Feature:
Macro ESI_MMIO_RO_ID_EN.
- Defined:
  - Register 0 reads as ID_VALUE.
  - A write to register 0 is not committed and returns error 3 (read-only).
  - Misaligned and out-of-range checks still take precedence over error 3.
- Undefined: register 0 is an ordinary read/write register, and error code 3 is never produced.

Decomposition:
- Package esi_mmio_pkg:
  - mmio_addr_t (32 bits), mmio_data_t (32 bits), mmio_err_t (8 bits).
  - Error constants MMIO_OK=0, MMIO_ERR_RANGE=1, MMIO_ERR_ALIGN=2, MMIO_ERR_RO=3.
  - Typedef for the packed read-response struct {data, err}.
- Sub-module esi_mmio_resp_fifo:
  - Parameterized width and depth; instantiated twice, 40 bits for reads and 8 bits for writes.
  - Holds the response FSM and the pointers.

Test Plan:
- Post-reset read: after reset, read addr 0x8 → data 0, err 0 at N+1. With the macro defined, read 0x0 → ID_VALUE.
- Write then read: write 0x4 = 0xCAFEF00D → err 0; then read 0x4 → 0xCAFEF00D, err 0.
- Address errors:
  - Read 0x6 → data 0, err 2.
  - Write 0x40 with NUM_REGS=16 → err 1, and all registers unchanged.
  - Write 0x0 with the macro defined → err 3; a later read of 0x0 → ID_VALUE.
- Back-pressure fill:
  - Hold rd_rsp_ready = 0 and issue 5 reads → exactly 4 accepted; rd_req_ready = 0 on the 5th.
  - Release rd_rsp_ready → the 4 responses drain in issue order with stable data while stalled.
- Same-cycle read and write: write 0xC = 0x11 and read 0xC in the same cycle → read returns the prior value 0; a next read → 0x11.
- Mid-operation reset: queue 3 write responses, assert rst asynchronously → wr_rsp_valid = 0 immediately, and all registers read 0 after release.
